// File: rtl/aes_seq_pkg.sv
// Shared types and sizes for the AES byte-serial sequencer.
package aes_seq_pkg;
  localparam int AES_BYTES = 16;
  localparam int AES_BITS  = 128;

  typedef enum logic [1:0] {IDLE, START, WAIT, DRAIN} seq_state_t;
endpackage

// File: rtl/aes_byte_shreg.sv
// Byte-wide shift register with a byte counter; serves key, plaintext and ciphertext.
module aes_byte_shreg #(
  parameter int NBYTES = 16,
  parameter int W      = 8 * NBYTES,
  parameter int CW     = $clog2(NBYTES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [W-1:0]  load_data,
  input  logic          shift,
  input  logic [7:0]    shift_in,
  input  logic          cnt_clr,
  input  logic          cnt_one,
  output logic [W-1:0]  data,
  output logic [CW-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
      cnt  <= '0;
    end else begin
      if (load)       data <= load_data;
      else if (shift) data <= {data[W-9:0], shift_in};
      // cnt_one restarts the count on the byte that begins a fresh field
      if (load || cnt_clr) cnt <= '0;
      else if (shift)      cnt <= cnt_one ? CW'(1) : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/aes_io_sequencer.sv
// Byte-serial loader, run controller and ciphertext streamer for the AES-128 core.
module aes_io_sequencer
  import aes_seq_pkg::*;
#(
  parameter int NBYTES      = AES_BYTES,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                in_sel,
  input  logic [7:0]          in_byte,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [7:0]          out_byte,
  output logic                core_start,
  output logic [AES_BITS-1:0] core_key,
  output logic [AES_BITS-1:0] core_pt,
  input  logic                core_done,
  input  logic [AES_BITS-1:0] core_ct,
  output logic                busy,
  output logic                key_valid,
  output logic                overrun,
  output logic                timeout_err,
  input  logic                clr_flags
);

  localparam int CW = $clog2(NBYTES + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(NBYTES);
  localparam logic [CW-1:0] CNT_LAST = CW'(NBYTES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  seq_state_t          state, state_d;
  logic [TW-1:0]       tmo_cnt, tmo_d;
  logic [CW-1:0]       key_cnt, pt_cnt, ct_idx;
  logic [AES_BITS-1:0] ct_data;
  logic                key_acc, pt_acc, ovr_set, tmo_set;
  logic                pt_clr, ct_load, ct_shift;
  logic                key_valid_d, pt_full_d;

  assign key_acc = in_valid && !in_sel && (state != WAIT);
  assign pt_acc  = in_valid && in_sel && (state == IDLE) && (pt_cnt < CNT_FULL);
  assign ovr_set = in_valid && (in_sel ? !pt_acc : (state == WAIT));

  // Look ahead one write so the block launches the cycle after its last byte.
  always_comb begin
    key_valid_d = key_valid;
    if (key_acc) key_valid_d = key_valid ? 1'b0 : (key_cnt == CNT_LAST);
  end
  assign pt_full_d = (pt_cnt == CNT_FULL) || (pt_acc && pt_cnt == CNT_LAST);

  aes_byte_shreg #(.NBYTES(NBYTES)) u_key (
    .clk, .rst, .load(1'b0), .load_data('0), .shift(key_acc), .shift_in(in_byte),
    .cnt_clr(1'b0), .cnt_one(key_valid), .data(core_key), .cnt(key_cnt)
  );

  aes_byte_shreg #(.NBYTES(NBYTES)) u_pt (
    .clk, .rst, .load(1'b0), .load_data('0), .shift(pt_acc), .shift_in(in_byte),
    .cnt_clr(pt_clr), .cnt_one(1'b0), .data(core_pt), .cnt(pt_cnt)
  );

  aes_byte_shreg #(.NBYTES(NBYTES)) u_ct (
    .clk, .rst, .load(ct_load), .load_data(core_ct), .shift(ct_shift), .shift_in(8'h00),
    .cnt_clr(1'b0), .cnt_one(1'b0), .data(ct_data), .cnt(ct_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      key_valid   <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state     <= state_d;
      tmo_cnt   <= tmo_d;
      key_valid <= key_valid_d;
      if (ovr_set)        overrun <= 1'b1;
      else if (clr_flags) overrun <= 1'b0;
      if (tmo_set)        timeout_err <= 1'b1;
      else if (clr_flags) timeout_err <= 1'b0;
    end
  end

  always_comb begin
    state_d    = state;
    tmo_d      = tmo_cnt;
    tmo_set    = 1'b0;
    pt_clr     = 1'b0;
    ct_load    = 1'b0;
    ct_shift   = 1'b0;
    core_start = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: if (pt_full_d && key_valid_d) state_d = START;
      START: begin
        core_start = 1'b1;
        tmo_d      = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        // done on the expiry cycle still counts as a completion
        if (core_done) begin
          ct_load = 1'b1;
          state_d = DRAIN;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_set = 1'b1;
          pt_clr  = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_cnt + 1'b1;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          ct_shift = 1'b1;
          if (ct_idx == CNT_LAST) begin
            pt_clr  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_byte = ct_data[AES_BITS-1 -: 8];
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_aes_io_sequencer.sv
// Scoreboard bench for aes_io_sequencer with a behavioural, latency-programmable AES core.
module tb_aes_io_sequencer;
  import aes_seq_pkg::*;

  localparam int TMO = 64;
  localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_sel = 1'b0, out_ready = 1'b0, clr_flags = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic out_valid, core_start, busy, key_valid, overrun, timeout_err;
  logic [7:0] out_byte;
  logic [127:0] core_key, core_pt;
  logic core_done = 1'b0;
  logic [127:0] core_ct = '0;

  aes_io_sequencer #(.NBYTES(16), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sel(in_sel), .in_byte(in_byte),
    .out_ready(out_ready), .out_valid(out_valid), .out_byte(out_byte),
    .core_start(core_start), .core_key(core_key), .core_pt(core_pt),
    .core_done(core_done), .core_ct(core_ct), .busy(busy), .key_valid(key_valid),
    .overrun(overrun), .timeout_err(timeout_err), .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Stand-in cipher: the FIPS-197 C.1 vector, otherwise an arbitrary mix.
  function automatic logic [127:0] ct_fn(input logic [127:0] k, input logic [127:0] p);
    if (k == FIPS_K && p == FIPS_P) return FIPS_C;
    return k ^ {p[63:0], p[127:64]} ^ 128'h5a5a_0f0f_3c3c_a5a5_1234_5678_9abc_def0;
  endfunction

  // Behavioural core; lat==0 means it never answers.
  int core_lat = 10;
  int inject_req = 0;
  int inject_ack = 0;
  int pend = 0;
  int starts = 0;
  logic [127:0] cap_key = '0, cap_pt = '0;

  always @(negedge clk) begin
    core_done = 1'b0;
    if (inject_ack != inject_req) begin
      core_done  = 1'b1;
      inject_ack = inject_req;
    end
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        core_done = 1'b1;
        core_ct   = ct_fn(cap_key, cap_pt);
      end
    end
    if (core_start) begin
      starts++;
      cap_key = core_key;
      cap_pt  = core_pt;
      pend    = core_lat;
    end
  end

  task automatic send(input logic sel, input logic [127:0] v, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_sel = sel; in_byte = v[127-8*i -: 8];
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [127:0] k, input logic [127:0] p);
    logic [127:0] c;
    c = ct_fn(k, p);
    for (int i = 0; i < 16; i++) exp_q.push_back(c[127-8*i -: 8]);
  endtask

  // mode 0: always ready; mode 1: ready toggles every cycle.
  task automatic drain(input int mode);
    int budget;
    logic stall;
    logic [7:0] held;
    budget = 300; stall = 1'b0; held = 8'h00;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
      if (stall && out_valid) chk("stall_hold", out_byte, held);
      if (out_valid && out_ready) chk("ct_byte", out_byte, exp_q.pop_front());
      stall = out_valid && !out_ready;
      held  = out_byte;
      @(posedge clk); #1;
      if (mode == 1) out_ready = !out_ready;
    end
    chk("drain_left", exp_q.size(), 0);
    out_ready = 1'b0;
  endtask

  logic [127:0] key_m, pt2, pt3, pt4, pt5;

  initial begin
    key_m = FIPS_K;
    pt2 = {$urandom, $urandom, $urandom, $urandom};
    pt3 = {$urandom, $urandom, $urandom, $urandom};
    pt4 = {$urandom, $urandom, $urandom, $urandom};
    pt5 = {$urandom, $urandom, $urandom, $urandom};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_outv", out_valid, 0);
    chk("rst_start", core_start, 0);
    chk("rst_kv", key_valid, 0);
    chk("rst_key", core_key, 0);
    chk("rst_flags", {overrun, timeout_err}, 0);
    @(posedge clk); #1; rst = 1'b0;

    // FIPS-197 C.1
    core_lat = 10;
    send(1'b0, FIPS_K, 0, 16);
    @(negedge clk);
    chk("kv_set", key_valid, 1);
    chk("idle_no_pt", busy, 0);
    push_exp(FIPS_K, FIPS_P);
    send(1'b1, FIPS_P, 0, 16);
    @(negedge clk);
    chk("start_lat", core_start, 1);
    drain(0);
    @(negedge clk);
    chk("c1_starts", starts, 1);
    chk("c1_key", cap_key, FIPS_K);
    chk("c1_pt", cap_pt, FIPS_P);
    chk("c1_busy_end", busy, 0);
    chk("c1_outv_end", out_valid, 0);

    // second block, key kept, ready toggling
    send(1'b1, pt2, 0, 15);
    repeat (3) @(negedge clk);
    chk("b2_wait15", busy, 0);
    push_exp(key_m, pt2);
    send(1'b1, pt2, 15, 1);
    @(negedge clk);
    chk("b2_start", core_start, 1);
    drain(1);
    chk("b2_starts", starts, 2);
    chk("b2_pt", cap_pt, pt2);
    chk("b2_kv", key_valid, 1);

    // timeout: core silent
    core_lat = 0;
    send(1'b1, pt3, 0, 16);
    @(negedge clk);
    chk("t_start", core_start, 1);
    repeat (TMO) @(negedge clk);
    chk("t_early", timeout_err, 0);
    @(negedge clk);
    chk("t_err", timeout_err, 1);
    chk("t_idle", busy, 0);
    inject_req++;
    repeat (3) @(negedge clk);
    chk("t_late_done", {busy, out_valid}, 0);
    @(posedge clk); #1; clr_flags = 1'b1;
    @(posedge clk); #1; clr_flags = 1'b0;
    @(negedge clk);
    chk("t_clr", timeout_err, 0);

    // overrun while the core runs
    core_lat = 30;
    push_exp(key_m, pt4);
    send(1'b1, pt4, 0, 16);
    @(negedge clk);
    chk("o_start", core_start, 1);
    send(1'b0, 128'hff00_0000_0000_0000_0000_0000_0000_0000, 0, 1);
    @(negedge clk);
    chk("o_key_ovr", overrun, 1);
    chk("o_key_same", core_key, key_m);
    @(posedge clk); #1; clr_flags = 1'b1;
    @(posedge clk); #1; clr_flags = 1'b0;
    @(negedge clk);
    chk("o_clr", overrun, 0);
    @(posedge clk); #1; clr_flags = 1'b1; in_valid = 1'b1; in_sel = 1'b1; in_byte = 8'hee;
    @(posedge clk); #1; clr_flags = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("o_set_wins", overrun, 1);
    chk("o_pt_same", core_pt, pt4);
    drain(0);
    chk("o_cap_key", cap_key, key_m);

    // reset in the middle of DRAIN
    core_lat = 5;
    push_exp(key_m, pt5);
    out_ready = 1'b1;
    send(1'b1, pt5, 0, 16);
    begin
      int n;
      n = 0;
      for (int k = 0; k < 100 && n < 5; k++) begin
        @(negedge clk);
        if (out_valid && out_ready) begin
          chk("r_byte", out_byte, exp_q.pop_front());
          n++;
        end
      end
      chk("r_got5", n, 5);
    end
    rst = 1'b1;
    #1;
    chk("r_outs", {out_valid, busy, core_start, key_valid, overrun, timeout_err}, 0);
    chk("r_byte0", out_byte, 0);
    chk("r_regs", core_key | core_pt, 0);
    exp_q.delete();
    out_ready = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("r_kv_after", key_valid, 0);

    // 17th pt byte with no key loaded
    send(1'b1, pt2, 0, 16);
    @(negedge clk);
    chk("p16_no_key", busy, 0);
    send(1'b1, 128'h7700_0000_0000_0000_0000_0000_0000_0000, 0, 1);
    @(negedge clk);
    chk("p17_ovr", overrun, 1);
    chk("p17_pt_same", core_pt, pt2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
